// File: rtl/generator_pkg.sv
// rtl/generator_pkg.sv - shared constants and width helper for the waveform generator path
package generator_pkg;

  // Default phase accumulator / increment width.
  localparam int DEF_ACC_W = 24;

  // Number of bits needed to count 0..value-1; shared with the address counter.
  function automatic int clogb2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/phase_acc.sv
// rtl/phase_acc.sv - phase accumulator with clear/run control and registered overflow strobe
module phase_acc
  import generator_pkg::*;
#(
  parameter int ACC_W = DEF_ACC_W
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_run,
  input  logic             i_clear,
  input  logic [ACC_W-1:0] i_inc,
  output logic             o_carry,
  output logic             o_up
);

  logic [ACC_W-1:0] r_acc;
  logic             r_up;
  logic [ACC_W:0]   w_sum;

  assign w_sum = {1'b0, r_acc} + {1'b0, i_inc};

  // Carry of the add actually performed this cycle; no add happens under clear or while stopped.
  assign o_carry = i_run & ~i_clear & w_sum[ACC_W];
  assign o_up    = r_up;

  // Accumulate while running, clear has priority, carry is registered into the strobe.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_acc <= '0;
      r_up  <= 1'b0;
    end else if (i_clear) begin
      r_acc <= '0;
      r_up  <= 1'b0;
    end else if (i_run) begin
      r_acc <= w_sum[ACC_W-1:0];
      r_up  <= w_sum[ACC_W];
    end else begin
      r_up  <= 1'b0;
    end
  end

endmodule

// File: rtl/rate_gen.sv
// rtl/rate_gen.sv - sample-rate strobe generator; RATE_GEN_IMMEDIATE_EN selects immediate increment updates
module rate_gen
  import generator_pkg::*;
#(
  parameter int ACC_W = DEF_ACC_W
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_run,
  input  logic             i_clear,
  input  logic [ACC_W-1:0] i_inc,
  input  logic             i_load_valid,
  output logic             o_load_ready,
  output logic [ACC_W-1:0] o_inc_active,
  output logic             o_up
);

  logic [ACC_W-1:0] r_inc_active;

  assign o_inc_active = r_inc_active;

`ifdef RATE_GEN_IMMEDIATE_EN

  phase_acc #(.ACC_W(ACC_W)) u_phase_acc (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_run   (i_run),
    .i_clear (i_clear),
    .i_inc   (r_inc_active),
    .o_carry (),
    .o_up    (o_up)
  );

  assign o_load_ready = 1'b1;

  // Every request takes effect on its own edge; phase continuity is not kept.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_inc_active <= '0;
    end else if (i_load_valid) begin
      r_inc_active <= i_inc;
    end
  end

`else

  logic [ACC_W-1:0] r_pend;
  logic             r_pend_v;
  logic             w_carry;
  logic             w_commit;
  logic             w_handshake;

  phase_acc #(.ACC_W(ACC_W)) u_phase_acc (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_run   (i_run),
    .i_clear (i_clear),
    .i_inc   (r_inc_active),
    .o_carry (w_carry),
    .o_up    (o_up)
  );

  // Swapping the increment is only safe at a period boundary, when stopped, or when idle at zero.
  assign w_commit     = ~i_run | (r_inc_active == '0) | w_carry;
  assign o_load_ready = ~r_pend_v;
  assign w_handshake  = i_load_valid & ~r_pend_v;

  // Commit directly when safe, otherwise park the value in the shadow register until the next carry.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_inc_active <= '0;
      r_pend       <= '0;
      r_pend_v     <= 1'b0;
    end else if (r_pend_v) begin
      if (w_commit) begin
        r_inc_active <= r_pend;
        r_pend_v     <= 1'b0;
      end
    end else if (w_handshake) begin
      if (w_commit) begin
        r_inc_active <= i_inc;
      end else begin
        r_pend   <= i_inc;
        r_pend_v <= 1'b1;
      end
    end
  end

`endif

endmodule

// File: doc/rate_gen.md
# rate_gen

Programmable sample-rate strobe generator for the waveform generator path. A phase accumulator advances by a loadable increment every enabled clock; each carry out of the accumulator emits a one-cycle `up` strobe. That strobe drives the increment input of the downstream modulo address counter, so the increment sets the output waveform frequency (f_up = f_clk · inc / 2^ACC_W).

## Interface
- `ACC_W`, 24, accumulator and increment width in bits; legal range 4..32.
- `clk`  in  1  system clock; all state updates on its rising edge.
- `rst`  in  1  reset, asynchronous, active-high; clears all state.
- `run`  in  1  level enable; accumulator advances only while high.
- `clear`  in  1  synchronous accumulator clear.
- `inc`  in  ACC_W  new increment value, sampled on handshake.
- `load_valid`  in  1  request to load `inc`.
- `load_ready`  out  1  load can be accepted this cycle.
- `inc_active`  out  ACC_W  increment currently in use.
- `up`  out  1  one-cycle strobe per accumulator overflow; feeds the address counter.

## Operation
- Registers: `acc` (ACC_W), `inc_active` (ACC_W), `pend` (ACC_W), `pend_v` (1), `up` (1).
- Reset values: `acc`=0, `inc_active`=0, `pend_v`=0, `up`=0, `load_ready`=1.
- Per edge:
  - With `clear`=1: `acc`<=0, `up`<=0. `clear` wins over `run`. Increment registers are unaffected.
  - With `run`=1 and `clear`=0: {carry, `acc`} <= `acc` + `inc_active` (ACC_W+1-bit add, modulo 2^ACC_W), and `up` <= carry.
  - With `run`=0 and `clear`=0: `acc` holds and `up`<=0.
- `load_ready` = !`pend_v`, combinational from the register. A handshake occurs when `load_valid` and `load_ready` are both high at an edge.
- Commit condition C in a cycle: `run`=0, or `inc_active`=0, or the current add produces a carry.
- On a handshake:
  - If C holds, `inc_active`<=`inc` directly.
  - Otherwise `pend`<=`inc` and `pend_v`<=1.
- While `pend_v`=1, at the first edge where C holds: `inc_active`<=`pend` and `pend_v`<=0. The new increment is first used by the add after the carry, which keeps phase continuous at the period boundary.
- `load_valid` while `load_ready`=0 is ignored. The requester must hold it.
- `clear` does not discard `pend`.
- `inc`=0 never produces `up`.
- `inc`=2^ACC_W−1 produces `up` on all but one cycle in every 2^ACC_W.

## Timing
- `up` is registered and asserted for exactly one cycle after the edge at which the overflowing add is performed.
- From a handshake (committed directly) to the first `up`: ceil(2^ACC_W / inc) + 1 edges, counted from an `acc`=0 start.
- A deferred commit happens on the same edge that sets `up`=1. `load_ready` returns high in the cycle where `up` is high.
- Asserting `rst` mid-operation discards any pending load. Outputs go to their reset values immediately and asynchronously.
- No combinational path from inputs to `up` or `inc_active`.

## Configuration
- `RATE_GEN_IMMEDIATE_EN`:
  - Defined: C is constant true, `pend` and `pend_v` are removed, `load_ready` is tied to 1, and every handshake updates `inc_active` on that edge. Phase is not preserved across frequency changes.
  - Undefined: deferred commit as described above.

## Structure
- Shared package `generator_pkg`: default `ACC_W`, and the `clogb2` function reused by the address counter for width computation.
- One natural sub-module, `phase_acc`: accumulator, `clear`/`run` muxing and registered carry to `up`.
- The `rate_gen` top holds the increment and shadow registers and the commit logic.
- Expected size: ~150 lines of RTL.

## Test plan
All scenarios use ACC_W=8.
- Reset: assert `rst` mid-run with `pend_v`=1 -> `up`=0, `inc_active`=0, `load_ready`=1 immediately; no `up` after release until a new load.
- Load `inc`=128 from reset with `run`=1 -> committed on the handshake edge; `up` high on every second cycle, first `up` 3 edges after the handshake.
- Load `inc`=3, `run`=1 for 256 cycles from `acc`=0 -> exactly 3 `up` pulses, spacing 85/86 cycles.
- Running at `inc`=64, load 128 mid-period -> `load_ready` low, `up` spacing stays 4 until the next `up`; after that the spacing is 2 and `load_ready` is back to 1.
- `run`=0 for 10 cycles with `acc`=192, `inc`=64 -> no `up`, `acc` holds; `run`=1 gives `up` after 1 edge. `clear` together with `run` -> `acc`=0 and no `up`.
- With `RATE_GEN_IMMEDIATE_EN` defined: load 128 mid-period at `inc`=64 -> `inc_active`=128 on the next edge; `load_ready` is constantly 1.
